// File: rtl/io_bus_register_slave_pkg.sv
// Shared types and constants for the IO_bus slave register block.
package io_bus_register_slave_pkg;

    localparam int unsigned IO_BUS_WIDTH  = 32;
    localparam int unsigned IO_ADDR_WIDTH = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } io_slave_state_t;

    // Request fields captured when a transaction is accepted
    typedef struct packed {
        logic [IO_ADDR_WIDTH-1:0] sel;
        logic                     is_write;
        logic [IO_BUS_WIDTH-1:0]  wdata;
    } io_req_t;

endpackage

// File: rtl/io_bus_if.sv
// Shared 32-bit IO_bus with a four-phase handshake between one master and many slaves.
interface IO_bus;
    import io_bus_register_slave_pkg::*;

    logic [IO_ADDR_WIDTH-1:0] reg_address;
    logic [IO_BUS_WIDTH-1:0]  data_out;
    logic [IO_BUS_WIDTH-1:0]  data_in;
    logic                     RW;
    logic                     handshake1_1;
    logic                     handshake1_2;

    modport master (
        output reg_address, data_out, RW, handshake1_1,
        input  data_in, handshake1_2
    );

    modport slave (
        input  reg_address, data_out, RW, handshake1_1,
        output data_in, handshake1_2
    );

endinterface

// File: rtl/io_bus_slave_handshake.sv
// Address decode, start-edge detection and four-phase handshake FSM for an IO_bus slave.
module io_bus_slave_handshake
    import io_bus_register_slave_pkg::*;
#(
    parameter logic [IO_ADDR_WIDTH-1:0] REG_BASE = 8'h00,
    parameter int unsigned              NUM_REGS = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IO_ADDR_WIDTH-1:0] reg_address,
    input  logic                     rw,
    input  logic [IO_BUS_WIDTH-1:0]  data_out,
    input  logic                     handshake1_1,
    output logic                     ack,
    output logic                     access_en,
    output logic                     is_write,
    output logic [IO_ADDR_WIDTH-1:0] reg_sel,
    output logic [IO_BUS_WIDTH-1:0]  wdata,
    output logic                     release_c
);

    io_slave_state_t          state;
    io_slave_state_t          state_next;
    logic                     h1_prev;
    logic                     ack_next;
    logic                     start_c;
    logic [IO_ADDR_WIDTH-1:0] offset_c;
    io_req_t                  req;

    assign offset_c = reg_address - REG_BASE;

    // Next state and handshake control
    always_comb begin
        state_next = state;
        ack_next   = ack;
        start_c    = 1'b0;
        release_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (handshake1_1 && !h1_prev &&
                    ({1'b0, offset_c} < (IO_ADDR_WIDTH + 1)'(NUM_REGS))) begin
                    start_c    = 1'b1;
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ack_next   = 1'b1;
                state_next = S_ACK;
            end
            S_ACK: begin
                if (!handshake1_1) begin
                    ack_next   = 1'b0;
                    release_c  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                ack_next   = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // h1_prev resets high so a strobe held through reset is never taken as a start
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ack       <= 1'b0;
            h1_prev   <= 1'b1;
            access_en <= 1'b0;
            req       <= '0;
        end else begin
            state     <= state_next;
            ack       <= ack_next;
            h1_prev   <= handshake1_1;
            access_en <= start_c;
            if (start_c) begin
                req <= '{sel: offset_c, is_write: (rw == RW_WRITE), wdata: data_out};
            end
        end
    end

    assign reg_sel  = req.sel;
    assign is_write = req.is_write;
    assign wdata    = req.wdata;

endmodule

// File: rtl/io_bus_register_slave.sv
// IO_bus register slave: read/write control bank plus read-only status words behind a handshake core.
module io_bus_register_slave
    import io_bus_register_slave_pkg::*;
#(
    parameter logic [IO_ADDR_WIDTH-1:0] REG_BASE    = 8'h00,
    parameter int unsigned              NUM_RW_REGS = 4,
    parameter int unsigned              NUM_RO_REGS = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    IO_bus.slave                                   bus,
    output logic [IO_BUS_WIDTH*NUM_RW_REGS-1:0]    ctrl_regs,
    output logic [NUM_RW_REGS-1:0]                 ctrl_wr_strobe,
    input  logic [IO_BUS_WIDTH*((NUM_RO_REGS == 0) ? 1 : NUM_RO_REGS)-1:0] status_in
);

    localparam int unsigned W        = IO_BUS_WIDTH;
    localparam int unsigned NUM_REGS = NUM_RW_REGS + NUM_RO_REGS;

    if ((int'(REG_BASE) + NUM_REGS > 256) || (NUM_RW_REGS < 1) ||
        (NUM_RW_REGS > 8) || (NUM_RO_REGS > 8)) begin : g_param_check
        $error("io_bus_register_slave: register window parameters out of range");
    end

    logic                     ack;
    logic                     access_en;
    logic                     is_write;
    logic                     release_c;
    logic [IO_ADDR_WIDTH-1:0] reg_sel;
    logic [W-1:0]             wdata;
    logic [W-1:0]             rdata;
    logic [W-1:0]             rd_mux_c;

    io_bus_slave_handshake #(
        .REG_BASE (REG_BASE),
        .NUM_REGS (NUM_REGS)
    ) u_handshake (
        .clk          (clk),
        .reset        (reset),
        .reg_address  (bus.reg_address),
        .rw           (bus.RW),
        .data_out     (bus.data_out),
        .handshake1_1 (bus.handshake1_1),
        .ack          (ack),
        .access_en    (access_en),
        .is_write     (is_write),
        .reg_sel      (reg_sel),
        .wdata        (wdata),
        .release_c    (release_c)
    );

    // Read multiplexer; status words are sampled live in the access cycle
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
            if (reg_sel == IO_ADDR_WIDTH'(k)) begin
                rd_mux_c = ctrl_regs[W*k +: W];
            end
        end
        for (int unsigned k = 0; k < NUM_RO_REGS; k++) begin
            if (reg_sel == IO_ADDR_WIDTH'(NUM_RW_REGS + k)) begin
                rd_mux_c = status_in[W*k +: W];
            end
        end
    end

    // Register bank; data_in stays 0 outside read acknowledges so slaves can be OR-combined
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_regs      <= '0;
            ctrl_wr_strobe <= '0;
            rdata          <= '0;
        end else begin
            ctrl_wr_strobe <= '0;
            if (access_en) begin
                if (is_write) begin
                    for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
                        if (reg_sel == IO_ADDR_WIDTH'(k)) begin
                            ctrl_regs[W*k +: W] <= wdata;
                            ctrl_wr_strobe[k]   <= 1'b1;
                        end
                    end
                end else begin
                    rdata <= rd_mux_c;
                end
            end else if (release_c) begin
                rdata <= '0;
            end
        end
    end

    assign bus.data_in      = rdata;
    assign bus.handshake1_2 = ack;

endmodule

// File: tb/tb_io_bus_register_slave.sv
// Self-checking bench for io_bus_register_slave: directed table, hand sequences and a random run.
module tb_io_bus_register_slave;
    import io_bus_register_slave_pkg::*;

    localparam logic [7:0] BASE = 8'h10;

    typedef struct {
        logic [7:0]   addr;
        logic         rw;
        logic [31:0]  wdata;
        logic [63:0]  status;
        logic         exp_ack;
        logic [31:0]  exp_rd;
        logic [3:0]   exp_stb;
        logic [127:0] exp_ctrl;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] ctrl_regs;
    logic [3:0]   ctrl_wr_strobe;
    logic [63:0]  status_in;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  mctrl [4];
    vec_t         vecs [12];

    IO_bus bus_if ();

    io_bus_register_slave #(
        .REG_BASE    (BASE),
        .NUM_RW_REGS (4),
        .NUM_RO_REGS (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if),
        .ctrl_regs      (ctrl_regs),
        .ctrl_wr_strobe (ctrl_wr_strobe),
        .status_in      (status_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_ctrl();
        return {mctrl[3], mctrl[2], mctrl[1], mctrl[0]};
    endfunction

    // One full four-phase transaction; bus fields are scrambled once the request is latched
    task automatic run_txn(input logic [7:0] addr, input logic rw, input logic [31:0] wdata,
                           input logic exp_ack, input logic [31:0] exp_rd,
                           input logic [3:0] exp_stb, input logic [127:0] exp_ctrl);
        int   lat;
        logic seen;
        @(negedge clk);
        bus_if.reg_address  = addr;
        bus_if.RW           = rw;
        bus_if.data_out     = wdata;
        bus_if.handshake1_1 = 1'b1;
        lat = 0;
        if (exp_ack) begin
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                @(posedge clk); #1;
                if (bus_if.handshake1_2) lat = c;
                if (c == 1) begin
                    bus_if.reg_address = 8'($urandom);
                    bus_if.data_out    = $urandom;
                    bus_if.RW          = ~rw;
                end
            end
            chk("ack_latency", 128'(lat), 128'd2);
            if (lat != 0) begin
                chk("data_in", 128'(bus_if.data_in), 128'(exp_rd));
                chk("wr_strobe", 128'(ctrl_wr_strobe), 128'(exp_stb));
                chk("ctrl_regs", ctrl_regs, exp_ctrl);
                @(posedge clk); #1;
                chk("ack_hold", 128'(bus_if.handshake1_2), 128'd1);
                chk("data_hold", 128'(bus_if.data_in), 128'(exp_rd));
                chk("strobe_one_cycle", 128'(ctrl_wr_strobe), 128'd0);
            end
        end else begin
            seen = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (bus_if.handshake1_2 || bus_if.data_in != 32'd0 || ctrl_wr_strobe != 4'd0)
                    seen = 1'b1;
                if (c == 1) begin
                    bus_if.reg_address = 8'($urandom);
                    bus_if.data_out    = $urandom;
                end
            end
            chk("no_response", 128'(seen), 128'd0);
            chk("ctrl_unchanged", ctrl_regs, exp_ctrl);
        end
        @(negedge clk);
        bus_if.handshake1_1 = 1'b0;
        @(posedge clk); #1;
        chk("release_ack", 128'(bus_if.handshake1_2), 128'd0);
        chk("release_data", 128'(bus_if.data_in), 128'd0);
    endtask

    initial begin
        logic        seen;
        logic [7:0]  addr;
        logic [7:0]  o;
        logic        rw;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_rd;
        logic [3:0]  exp_stb;
        int          waited;

        vecs[0]  = '{8'h10, RW_WRITE, 32'hAAAA_0001, 64'hCAFE_F00D_0000_1234, 1'b1, 32'h0, 4'b0001,
                     {32'h0, 32'h0, 32'h0, 32'hAAAA_0001}};
        vecs[1]  = '{8'h12, RW_WRITE, 32'hDEAD_BEEF, 64'hCAFE_F00D_0000_1234, 1'b1, 32'h0, 4'b0100,
                     {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[2]  = '{8'h12, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b1, 32'hDEAD_BEEF, 4'b0000,
                     {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[3]  = '{8'h14, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b1, 32'h0000_1234, 4'b0000,
                     {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[4]  = '{8'h14, RW_WRITE, 32'hFFFF_FFFF, 64'hCAFE_F00D_0000_1234, 1'b1, 32'h0, 4'b0000,
                     {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[5]  = '{8'h15, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b1, 32'hCAFE_F00D, 4'b0000,
                     {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[6]  = '{8'h13, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b1, 32'h0, 4'b0000,
                     {32'h0, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[7]  = '{8'h13, RW_WRITE, 32'h0000_0001, 64'hCAFE_F00D_0000_1234, 1'b1, 32'h0, 4'b1000,
                     {32'h1, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[8]  = '{8'h10, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b1, 32'hAAAA_0001, 4'b0000,
                     {32'h1, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[9]  = '{8'h16, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b0, 32'h0, 4'b0000,
                     {32'h1, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[10] = '{8'h0F, RW_READ, 32'h0, 64'hCAFE_F00D_0000_1234, 1'b0, 32'h0, 4'b0000,
                     {32'h1, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};
        vecs[11] = '{8'hFF, RW_WRITE, 32'h1234_5678, 64'hCAFE_F00D_0000_1234, 1'b0, 32'h0, 4'b0000,
                     {32'h1, 32'hDEAD_BEEF, 32'h0, 32'hAAAA_0001}};

        // Strobe held high through reset must not start a transaction
        reset               = 1'b1;
        status_in           = 64'd0;
        bus_if.reg_address  = BASE;
        bus_if.RW           = RW_WRITE;
        bus_if.data_out     = 32'h5555_5555;
        bus_if.handshake1_1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 128'(bus_if.handshake1_2), 128'd0);
        chk("reset_ctrl", ctrl_regs, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus_if.handshake1_2 || bus_if.data_in != 32'd0 ||
                ctrl_wr_strobe != 4'd0 || ctrl_regs != 128'd0)
                seen = 1'b1;
        end
        chk("held_strobe_ignored", 128'(seen), 128'd0);
        @(negedge clk);
        bus_if.handshake1_1 = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            status_in = vecs[i].status;
            run_txn(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].exp_ack,
                    vecs[i].exp_rd, vecs[i].exp_stb, vecs[i].exp_ctrl);
        end

        mctrl[0] = 32'hAAAA_0001;
        mctrl[1] = 32'h0;
        mctrl[2] = 32'hDEAD_BEEF;
        mctrl[3] = 32'h1;

        // Random traffic against the address-map model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) addr = 8'($urandom);
            else                           addr = BASE + 8'($urandom_range(0, 7));
            rw        = 1'($urandom);
            wdata     = $urandom;
            status_in = {$urandom, $urandom};
            o         = addr - BASE;
            exp_ack   = (o < 8'd6);
            exp_rd    = 32'd0;
            exp_stb   = 4'd0;
            if (exp_ack && rw == RW_READ) begin
                if (o < 8'd4)       exp_rd = mctrl[o[1:0]];
                else if (o == 8'd4) exp_rd = status_in[31:0];
                else                exp_rd = status_in[63:32];
            end
            if (exp_ack && rw == RW_WRITE && o < 8'd4) begin
                mctrl[o[1:0]] = wdata;
                exp_stb       = 4'(1 << o[1:0]);
            end
            run_txn(addr, rw, wdata, exp_ack, exp_rd, exp_stb, pack_ctrl());
        end

        // Reset while acknowledging a read
        @(negedge clk);
        bus_if.reg_address  = BASE + 8'd2;
        bus_if.RW           = RW_READ;
        bus_if.handshake1_1 = 1'b1;
        waited = 0;
        while (!bus_if.handshake1_2 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("ack_before_reset", 128'(bus_if.handshake1_2), 128'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_ack", 128'(bus_if.handshake1_2), 128'd0);
        chk("mid_reset_data", 128'(bus_if.data_in), 128'd0);
        chk("mid_reset_ctrl", ctrl_regs, 128'd0);
        chk("mid_reset_strobe", 128'(ctrl_wr_strobe), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus_if.handshake1_2) seen = 1'b1;
        end
        chk("no_restart_after_reset", 128'(seen), 128'd0);
        @(negedge clk);
        bus_if.handshake1_1 = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) mctrl[k] = 32'd0;
        mctrl[1] = 32'h0BAD_F00D;
        run_txn(BASE + 8'd1, RW_WRITE, 32'h0BAD_F00D, 1'b1, 32'd0, 4'b0010, pack_ctrl());
        run_txn(BASE + 8'd1, RW_READ, 32'd0, 1'b1, 32'h0BAD_F00D, 4'b0000, pack_ctrl());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
